// File: rtl/nn_pkg.sv
// Shared definitions for the classifier output selectors: default score
// geometry, selector state encoding and an index-width helper.
package nn_pkg;

  localparam int SCORE_W     = 26;
  localparam int NUM_CLASSES = 10;

  localparam logic ST_ACCUM = 1'b0;
  localparam logic ST_DONE  = 1'b1;

  typedef enum logic {
    S_ACCUM = ST_ACCUM,
    S_DONE  = ST_DONE
  } sel_state_e;

  // Index width never drops below one bit, even for a single class.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/score_cmp_gt.sv
// Strict greater-than compare of two scores, two's-complement or unsigned
// depending on SIGNED_MODE. Purely combinational.
module score_cmp_gt #(
  parameter int WIDTH       = 26,
  parameter int SIGNED_MODE = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             a_gt_b
);

  generate
    if (SIGNED_MODE != 0) begin : g_signed
      assign a_gt_b = $signed(a) > $signed(b);
    end else begin : g_unsigned
      assign a_gt_b = a > b;
    end
  endgenerate

endmodule

// File: rtl/argmax_stream_selector.sv
// Streaming argmax: one score per accepted beat, running max/index, one
// {idx, max, err} result per frame on a held valid/ready output.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_ACCUM | accepting beats, tracking running best (in_ready=1)
//   S_DONE  | frame closed, result held until out_ready (out_valid=1)
module argmax_stream_selector
  import nn_pkg::*;
#(
  parameter int WIDTH       = nn_pkg::SCORE_W,
  parameter int NUM_CLASSES = nn_pkg::NUM_CLASSES,
  parameter int SIGNED_MODE = 1,
  localparam int IDX_W      = nn_pkg::idx_width(NUM_CLASSES)
) (
  input  logic             clk,
  input  logic             GlobalReset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [WIDTH-1:0] out_max,
  output logic             out_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  sel_state_e       state_q, state_d;
  logic [IDX_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [WIDTH-1:0] best_q, best_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic [WIDTH-1:0] out_max_q, out_max_d;
  logic             out_err_q, out_err_d;

  logic             in_gt_best;
  logic             beat_acc;
  logic             at_end;
  logic             take;
  logic [WIDTH-1:0] cand_max;
  logic [IDX_W-1:0] cand_idx;

  score_cmp_gt #(
    .WIDTH       (WIDTH),
    .SIGNED_MODE (SIGNED_MODE)
  ) u_cmp (
    .a      (in_data),
    .b      (best_q),
    .a_gt_b (in_gt_best)
  );

  assign beat_acc = in_valid && (state_q == S_ACCUM);
  assign at_end   = (count_q == LAST_IDX);
  // First beat of a frame seeds the best regardless of the stale best_q.
  assign take     = (count_q == '0) || in_gt_best;
  assign cand_max = take ? in_data : best_q;
  assign cand_idx = take ? count_q : best_idx_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    out_idx_d  = out_idx_q;
    out_max_d  = out_max_q;
    out_err_d  = out_err_q;
    case (state_q)
      S_ACCUM: begin
        if (beat_acc) begin
          best_d     = cand_max;
          best_idx_d = cand_idx;
          if (in_last || at_end) begin
            state_d   = S_DONE;
            count_d   = '0;
            out_idx_d = cand_idx;
            out_max_d = cand_max;
            // Short frame or missing last: exactly one of the two is set.
            out_err_d = in_last ^ at_end;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_ACCUM;
      end
      default: state_d = S_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      state_q    <= S_ACCUM;
      count_q    <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      out_idx_q  <= '0;
      out_max_q  <= '0;
      out_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      out_idx_q  <= out_idx_d;
      out_max_q  <= out_max_d;
      out_err_q  <= out_err_d;
    end
  end

  assign in_ready  = (state_q == S_ACCUM);
  assign out_valid = (state_q == S_DONE);
  assign out_idx   = out_idx_q;
  assign out_max   = out_max_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_argmax_stream_selector.sv
// Scoreboard bench: a signed and an unsigned selector share one input stream;
// expected results are queued per frame and popped on each output handshake.
module tb_argmax_stream_selector;

  localparam int W  = 26;
  localparam int NC = 10;
  localparam int IW = 4;

  typedef struct {
    logic [IW-1:0] idx_s;
    logic [W-1:0]  max_s;
    logic [IW-1:0] idx_u;
    logic [W-1:0]  max_u;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          GlobalReset = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_last = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready, out_valid, out_err;
  logic [IW-1:0] out_idx;
  logic [W-1:0]  out_max;
  logic          in_ready_u, out_valid_u, out_err_u;
  logic [IW-1:0] out_idx_u;
  logic [W-1:0]  out_max_u;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc, f_first, f_last;
  bit   rand_rdy = 0;
  exp_t exp_q[$];
  logic [W-1:0] fr[NC];

  argmax_stream_selector #(.WIDTH(W), .NUM_CLASSES(NC), .SIGNED_MODE(1)) dut_s (
    .clk(clk), .GlobalReset(GlobalReset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_max(out_max), .out_err(out_err));

  argmax_stream_selector #(.WIDTH(W), .NUM_CLASSES(NC), .SIGNED_MODE(0)) dut_u (
    .clk(clk), .GlobalReset(GlobalReset), .in_valid(in_valid), .in_ready(in_ready_u),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_u), .out_ready(out_ready),
    .out_idx(out_idx_u), .out_max(out_max_u), .out_err(out_err_u));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare both selectors whenever a result is handed over.
  always @(negedge clk) begin
    if (!GlobalReset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual idx=%0d max=0x%0h expected none", out_idx, out_max);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("idx_signed", 32'(out_idx), 32'(e.idx_s));
        chk("max_signed", 32'(out_max), 32'(e.max_s));
        chk("err_signed", 32'(out_err), 32'(e.err));
        chk("valid_unsigned", 32'(out_valid_u), 32'd1);
        chk("idx_unsigned", 32'(out_idx_u), 32'(e.idx_u));
        chk("max_unsigned", 32'(out_max_u), 32'(e.max_u));
        chk("err_unsigned", 32'(out_err_u), 32'(e.err));
      end
    end
  end

  function automatic logic [W-1:0] s(input int v);
    logic [31:0] t;
    t = v;
    return t[W-1:0];
  endfunction

  task automatic expect_res(input int is_, input int ms, input int iu, input int mu, input bit err);
    exp_t e;
    e.idx_s = IW'(is_);
    e.max_s = s(ms);
    e.idx_u = IW'(iu);
    e.max_u = s(mu);
    e.err   = err;
    exp_q.push_back(e);
  endtask

  // Reference argmax over fr[0..n-1], lowest index wins ties.
  function automatic exp_t ref_model(input int n, input bit last);
    exp_t e;
    e.idx_s = '0; e.max_s = fr[0];
    e.idx_u = '0; e.max_u = fr[0];
    for (int i = 1; i < n; i++) begin
      if ($signed(fr[i]) > $signed(e.max_s)) begin e.max_s = fr[i]; e.idx_s = IW'(i); end
      if (fr[i] > e.max_u) begin e.max_u = fr[i]; e.idx_u = IW'(i); end
    end
    e.err = (n != NC) || !last;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic beat(input logic [W-1:0] d, input logic last, input int gap);
    bit rdy, acc;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    acc = 0;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      rdy = in_ready;
      tick();
      if (rdy) acc = 1;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL beat_accept_timeout actual=not_accepted expected=accepted");
    end
    acc_cyc  = cyc;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit last, input bit gaps);
    for (int i = 0; i < n; i++) begin
      beat(fr[i], last && (i == n - 1), gaps ? int'($urandom_range(0, 1)) : 0);
      if (i == 0) f_first = acc_cyc;
      f_last = acc_cyc;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) tick();
    tick();
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    GlobalReset = 1'b1;
    in_valid    = 1'b0;
    @(posedge clk);
    #1;
    GlobalReset = 1'b0;
    exp_q.delete();
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_idx"}, 32'(out_idx), 32'd0);
    chk({tag, "_out_max"}, 32'(out_max), 32'd0);
    chk({tag, "_out_err"}, 32'(out_err), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid_u"}, 32'(out_valid_u), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    do_reset("reset");
    out_ready = 1'b1;

    // Directed frames with hand-computed signed/unsigned results.
    fr = '{s(5), s(-3), s(7), s(7), s(0), s(-100), s(2), s(1), s(6), s(3)};
    expect_res(2, 7, 1, -3, 0);
    send_frame(10, 1, 0);
    fr = '{s(-1), s(-2), s(-3), s(-4), s(-5), s(-6), s(-7), s(-8), s(-9), s(-10)};
    expect_res(0, -1, 0, -1, 0);
    send_frame(10, 1, 0);
    fr = '{s(-10), s(-9), s(-8), s(-7), s(-6), s(-5), s(-4), s(-3), s(-2), s(-1)};
    expect_res(9, -1, 9, -1, 0);
    send_frame(10, 1, 1);
    fr = '{s(1), s(9), s(4), s(2), s(0), s(0), s(0), s(0), s(0), s(0)};
    expect_res(1, 9, 1, 9, 1);
    send_frame(4, 1, 0);
    fr = '{s(0), s(1), s(2), s(3), s(4), s(5), s(6), s(7), s(8), s(9)};
    expect_res(9, 9, 9, 9, 1);
    send_frame(10, 0, 0);
    fr = '{s(2), s(8), s(8), s(1), s(0), s(0), s(0), s(0), s(0), s(0)};
    expect_res(1, 8, 1, 8, 0);
    send_frame(10, 1, 0);
    drain();

    // Backpressure: result must hold while out_ready is low.
    fr = '{s(7), s(1), s(1), s(1), s(1), s(1), s(1), s(1), s(1), s(7)};
    out_ready = 1'b0;
    expect_res(0, 7, 0, 7, 0);
    send_frame(10, 1, 0);
    repeat (5) begin
      @(negedge clk);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_idx", 32'(out_idx), 32'd0);
      chk("stall_out_max", 32'(out_max), 32'd7);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_out_valid", 32'(out_valid), 32'd0);
    drain();

    // Back-to-back frames: exactly one bubble between them.
    begin
      int l1;
      expect_res(0, 7, 0, 7, 0);
      expect_res(0, 7, 0, 7, 0);
      send_frame(10, 1, 0);
      l1 = f_last;
      send_frame(10, 1, 0);
      chk("bubble_cycles", 32'(f_first - l1), 32'd2);
      drain();
    end

    // Reset mid-frame discards the partial frame.
    fr = '{s(50), s(50), s(50), s(50), s(0), s(0), s(0), s(0), s(0), s(0)};
    send_frame(4, 0, 0);
    do_reset("rst_mid");
    fr = '{s(1), s(2), s(3), s(30), s(5), s(6), s(7), s(8), s(9), s(10)};
    expect_res(3, 30, 3, 30, 0);
    send_frame(10, 1, 0);
    drain();

    // Reset while a result is held drops it.
    out_ready = 1'b0;
    fr = '{s(0), s(0), s(99), s(0), s(0), s(0), s(0), s(0), s(0), s(0)};
    expect_res(2, 99, 2, 99, 0);
    send_frame(10, 1, 0);
    chk("done_before_reset", 32'(out_valid), 32'd1);
    do_reset("rst_done");
    out_ready = 1'b1;
    fr = '{s(9), s(1), s(1), s(1), s(1), s(1), s(1), s(1), s(1), s(1)};
    expect_res(0, 9, 0, 9, 0);
    send_frame(10, 1, 0);
    drain();

    // Random frames with gapped valid and random out_ready.
    rand_rdy = 1;
    for (int f = 0; f < 1000; f++) begin
      int n;
      bit last;
      n = $urandom_range(1, NC);
      last = (n == NC) ? bit'($urandom_range(0, 1)) : 1'b1;
      for (int i = 0; i < NC; i++)
        fr[i] = ($urandom_range(0, 3) != 0) ? s(int'($urandom_range(0, 15)) - 8) : s(int'($urandom));
      exp_q.push_back(ref_model(n, last));
      send_frame(n, last, 1);
    end
    rand_rdy = 0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
